// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, press/release debounce and key decode.
// Emits one single-cycle num/OP/C/EQ pulse per accepted press.
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       num,
    output logic       OP,
    output logic       C,
    output logic       EQ,
    output logic [3:0] digit,
    output logic [1:0] op_code
);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t            state, state_nx;
    logic [3:0]        col_m, col_s;
    logic [1:0]        row_idx, row_nx;
    logic [1:0]        lat_col, lat_col_nx;
    logic [1:0]        low_col;
    logic [CNT_W-1:0]  dwell_cnt, dwell_nx;
    logic [CNT_W-1:0]  db_cnt, db_nx;
    logic              num_q, op_q, c_q, eq_q;
    logic              num_nx, op_nx, c_nx, eq_nx;
    logic [3:0]        digit_q, digit_nx;
    logic [1:0]        op_code_q, op_code_nx;
    logic              lat_bit;

    assign row_n   = ~(4'b0001 << row_idx);
    assign num     = num_q;
    assign OP      = op_q;
    assign C       = c_q;
    assign EQ      = eq_q;
    assign digit   = digit_q;
    assign op_code = op_code_q;
    assign lat_bit = col_s[lat_col];

    // Lowest-numbered low column wins when several keys share a row.
    always_comb begin
        low_col = 2'd3;
        if (!col_s[0])      low_col = 2'd0;
        else if (!col_s[1]) low_col = 2'd1;
        else if (!col_s[2]) low_col = 2'd2;
    end

    always_comb begin
        state_nx   = state;
        row_nx     = row_idx;
        lat_col_nx = lat_col;
        dwell_nx   = dwell_cnt;
        db_nx      = db_cnt;
        num_nx     = 1'b0;
        op_nx      = 1'b0;
        c_nx       = 1'b0;
        eq_nx      = 1'b0;
        digit_nx   = digit_q;
        op_code_nx = op_code_q;
        case (state)
            SCAN: begin
                if (dwell_cnt >= DWELL_END) begin
                    dwell_nx = '0;
                    if (col_s != 4'b1111) begin
                        state_nx   = DEBOUNCE;
                        lat_col_nx = low_col;
                        db_nx      = '0;
                    end else begin
                        row_nx = row_idx + 2'd1;
                    end
                end else begin
                    dwell_nx = dwell_cnt + ONE;
                end
            end
            DEBOUNCE: begin
                if (lat_bit) begin
                    state_nx = SCAN;
                    row_nx   = row_idx + 2'd1;
                    dwell_nx = '0;
                    db_nx    = '0;
                end else if (db_cnt >= DB_LAST) begin
                    state_nx = EMIT;
                    // Decode registered here so pulse and value land in the EMIT cycle.
                    if (lat_col == 2'd3) begin
                        op_nx      = 1'b1;
                        op_code_nx = row_idx;
                    end else if (row_idx != 2'd3) begin
                        num_nx   = 1'b1;
                        digit_nx = {2'b00, row_idx} * 4'd3 + {2'b00, lat_col} + 4'd1;
                    end else if (lat_col == 2'd1) begin
                        num_nx   = 1'b1;
                        digit_nx = 4'd0;
                    end else if (lat_col == 2'd0) begin
                        c_nx = 1'b1;
                    end else begin
                        eq_nx = 1'b1;
                    end
                end else if (db_cnt != '1) begin
                    db_nx = db_cnt + ONE;
                end
            end
            EMIT: begin
                state_nx = WAIT_RELEASE;
                db_nx    = '0;
            end
            WAIT_RELEASE: begin
                if (!lat_bit) begin
                    db_nx = '0;
                end else if (db_cnt >= DB_LAST) begin
                    state_nx = SCAN;
                    row_nx   = row_idx + 2'd1;
                    dwell_nx = '0;
                    db_nx    = '0;
                end else if (db_cnt != '1) begin
                    db_nx = db_cnt + ONE;
                end
            end
            default: state_nx = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            col_m     <= 4'b1111;
            col_s     <= 4'b1111;
            row_idx   <= 2'd0;
            lat_col   <= 2'd0;
            dwell_cnt <= '0;
            db_cnt    <= '0;
            num_q     <= 1'b0;
            op_q      <= 1'b0;
            c_q       <= 1'b0;
            eq_q      <= 1'b0;
            digit_q   <= 4'd0;
            op_code_q <= 2'd0;
        end else begin
            state     <= state_nx;
            col_m     <= col_n;
            col_s     <= col_m;
            row_idx   <= row_nx;
            lat_col   <= lat_col_nx;
            dwell_cnt <= dwell_nx;
            db_cnt    <= db_nx;
            num_q     <= num_nx;
            op_q      <= op_nx;
            c_q       <= c_nx;
            eq_q      <= eq_nx;
            digit_q   <= digit_nx;
            op_code_q <= op_code_nx;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives col_n from row_n,
// expected key events are queued at press time and matched against observed pulses.
module tb_keypad_scanner;

    typedef struct packed {
        logic       multi;
        logic [1:0] kind;   // 0 num, 1 OP, 2 C, 3 EQ
        logic [3:0] digit;
        logic [1:0] op;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic       num, OP, C, EQ;
    logic [3:0] digit;
    logic [1:0] op_code;

    logic [3:0][3:0] keys;   // keys[row][col] = 1 when held
    ev_t exp_q[$];
    ev_t obs_q[$];
    logic [3:0] exp_digit;
    logic [1:0] exp_op;
    int checks = 0;
    int errors = 0;

    keypad_scanner dut (
        .clk(clk), .reset(reset), .col_n(col_n), .row_n(row_n),
        .num(num), .OP(OP), .C(C), .EQ(EQ), .digit(digit), .op_code(op_code)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r][c] && !row_n[r]) col_n[c] = 1'b0;
    end

    task automatic tick(input int n);
        ev_t o;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (num | OP | C | EQ) begin
                o.multi = (32'(num) + 32'(OP) + 32'(C) + 32'(EQ)) > 1;
                o.kind  = num ? 2'd0 : OP ? 2'd1 : C ? 2'd2 : 2'd3;
                o.digit = digit;
                o.op    = op_code;
                obs_q.push_back(o);
            end
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind);
        ev_t e;
        e.multi = 1'b0;
        e.kind  = kind;
        e.digit = exp_digit;
        e.op    = exp_op;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        logic [3:0] er;
        reset = 1'b1;
        keys  = '0;
        tick(2);
        reset = 1'b0;
        exp_digit = 4'd0;
        exp_op    = 2'd0;
        checks++;
        if ({row_n, num, OP, C, EQ, digit, op_code} !== {4'b1110, 4'b0000, 4'd0, 2'd0}) begin
            errors++;
            $display("FAIL reset_values: got row_n=%b pulses=%b%b%b%b digit=%0d op=%0d want 1110 0000 0 0",
                     row_n, num, OP, C, EQ, digit, op_code);
        end
        for (int k = 1; k <= 32; k++) begin
            tick(1);
            er = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (row_n !== er) begin
                errors++;
                $display("FAIL idle_scan k=%0d: got row_n=%b want %b", k, row_n, er);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL idle_pulses: got %0d events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_hold_5;
        ev_t e, o;
        keys[1][1] = 1'b1;
        exp_digit  = 4'd5;
        expect_ev(2'd0);
        tick(200);
        checks++;
        if (row_n !== 4'b1101) begin
            errors++;
            $display("FAIL hold5_frozen: got row_n=%b want 1101", row_n);
        end
        keys = '0;
        tick(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL hold5_event: got none want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL hold5_event: got %h want %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL hold5_extra: got %0d extra events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_bounce_7;
        ev_t e, o;
        for (int i = 0; i < 10; i++) begin
            keys[2][0] = (i % 2 == 0);
            tick(3);
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL bounce_quiet: got %0d events want 0", obs_q.size());
            obs_q.delete();
        end
        keys[2][0] = 1'b1;
        exp_digit  = 4'd7;
        expect_ev(2'd0);
        tick(60);
        keys = '0;
        tick(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL bounce7_event: got none want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL bounce7_event: got %h want %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL bounce7_extra: got %0d extra events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_ops;
        ev_t e, o;
        int rr[4] = '{0, 3, 3, 3};
        int cc[4] = '{3, 3, 0, 2};
        logic [1:0] kk[4] = '{2'd1, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 4; i++) begin
            keys = '0;
            keys[rr[i]][cc[i]] = 1'b1;
            if (kk[i] == 2'd1) exp_op = 2'(rr[i]);
            expect_ev(kk[i]);
            tick(60);
            keys = '0;
            tick(40);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL ops_event: got none want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL ops_event: got %h want %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL ops_extra: got %0d extra events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_same_row;
        ev_t e, o;
        keys[3][1] = 1'b1;
        keys[3][2] = 1'b1;
        exp_digit  = 4'd0;
        expect_ev(2'd0);
        tick(60);
        checks++;
        if (row_n !== 4'b0111) begin
            errors++;
            $display("FAIL same_row_frozen: got row_n=%b want 0111", row_n);
        end
        keys = '0;
        tick(40);
        keys[3][2] = 1'b1;
        expect_ev(2'd3);
        tick(60);
        keys = '0;
        tick(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL same_row_event: got none want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL same_row_event: got %h want %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL same_row_extra: got %0d extra events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        keys[2][2] = 1'b1;
        // Row 2 is sampled at k=11, so k=12..19 is the press debounce window.
        tick(15);
        checks++;
        if (row_n !== 4'b1011) begin
            errors++;
            $display("FAIL mid_frozen: got row_n=%b want 1011", row_n);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        keys  = '0;
        exp_digit = 4'd0;
        exp_op    = 2'd0;
        checks++;
        if ({row_n, num, OP, C, EQ, digit, op_code} !== {4'b1110, 4'b0000, 4'd0, 2'd0}) begin
            errors++;
            $display("FAIL mid_reset_values: got row_n=%b pulses=%b%b%b%b digit=%0d op=%0d want 1110 0000 0 0",
                     row_n, num, OP, C, EQ, digit, op_code);
        end
        tick(4);
        checks++;
        if (row_n !== 4'b1101) begin
            errors++;
            $display("FAIL mid_restart: got row_n=%b want 1101", row_n);
        end
        tick(40);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL mid_no_pulse: got %0d events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        keys  = '0;
        exp_digit = 4'd0;
        exp_op    = 2'd0;
        test_reset();
        test_hold_5();
        test_bounce_7();
        test_ops();
        test_same_row();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Producer end of the calculator key-event interface: scans a 4x4 matrix keypad, debounces presses and releases, and decodes each key.
- Emits exactly one single-cycle event pulse per physical press on num, OP, C or EQ, the inputs consumed by the calculator control FSM.
- Latches the decoded digit or operator code for the datapath save registers.

Parameters:
SCAN_DIV, 4, clock cycles each row is driven during scanning (must be >= 3)
DEBOUNCE_CYCLES, 8, consecutive stable cycles required to accept a press or a release (must be >= 2)
CNT_W, 16, width of the dwell and debounce counters (must hold max(SCAN_DIV, DEBOUNCE_CYCLES))

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
col_n  input  4  keypad column lines, active-low (pulled up), asynchronous to clk
row_n  output  4  keypad row drive, active-low one-hot
num  output  1  one-cycle pulse: digit key 0-9 accepted
OP  output  1  one-cycle pulse: operator key accepted
C  output  1  one-cycle pulse: clear key accepted
EQ  output  1  one-cycle pulse: equals key accepted
digit  output  4  last accepted digit, 0-9
op_code  output  2  last accepted operator: 00 add, 01 sub, 10 mul, 11 div

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values: row_n=4'b1110, num=OP=C=EQ=0, digit=0, op_code=00, state=SCAN, row index=0, all counters=0, synchronizer stages=4'b1111.
- Synchronizer: col_n passes through a 2-flop synchronizer giving col_s. All decisions use col_s only.
- Key map (row,col):
  - r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: *,0,#,D.
  - A/B/C/D -> OP with op_code 00/01/10/11.
  - * -> C; # -> EQ; digits -> num.
- State SCAN:
  - Row index advances 0->1->2->3->0 every SCAN_DIV cycles; row_n = ~(1<<row index).
  - Evaluation happens only on the last dwell cycle of each row, after the sync settles.
  - If col_s != 1111 at evaluation: latch row index and the lowest-numbered low column, go to DEBOUNCE, freeze row_n on that row, clear the debounce counter.
  - Otherwise advance to the next row.
- State DEBOUNCE:
  - Latched column bit low: increment counter. Counter reaches DEBOUNCE_CYCLES-1 with bit still low -> EMIT.
  - Latched column bit high on any cycle: abandon the press and return to SCAN at the next row. No pulse is produced.
- State EMIT (exactly 1 cycle):
  - The decoded pulse output is registered high for that cycle only; digit or op_code updates in the same cycle.
  - Accepting C or EQ leaves digit and op_code unchanged. Accepting num leaves op_code unchanged; accepting OP leaves digit unchanged.
  - Next state is WAIT_RELEASE.
- State WAIT_RELEASE:
  - row_n stays frozen on the latched row; counter cleared on entry.
  - Counter counts consecutive cycles with the latched column high and clears on any low cycle.
  - Reaching DEBOUNCE_CYCLES-1 -> SCAN at the next row, dwell counter 0.
  - There is no auto-repeat; a held key produces exactly one pulse.
- Pulse rules: at most one of num/OP/C/EQ is high in any cycle; each pulse is exactly one cycle wide.
- Simultaneous keys:
  - Same row: lowest column wins.
  - Other rows: ignored until the latched key is released and scanning resumes.
  - A second key pressed in the latched row during WAIT_RELEASE is ignored, because only the latched column is watched.
- Latency: minimum from a stable press on the currently driven row to the pulse = sync (2) + remaining dwell + DEBOUNCE_CYCLES + 1 cycles.
- Reset mid-operation: in any state, the cycle after reset is high all outputs equal their reset values. A pending press is discarded and no pulse is emitted for it.
- Counters saturate; they never wrap in any state.

Test Plan:
(All scenarios use the defaults SCAN_DIV=4, DEBOUNCE_CYCLES=8.)
1. Reset, col_n=1111 for 32 cycles -> row_n cycles 1110,1101,1011,0111, each for 4 cycles; num=OP=C=EQ=0 throughout.
2. Hold key '5' (col_n=1101 while row_n=1101) for 200 cycles -> exactly one num pulse of 1 cycle, digit=5; row_n frozen at 1101 until release.
3. Key '7' bounces (col toggles every 3 cycles for 30 cycles) then stays stable low -> zero pulses during the bounce, then exactly one num pulse with digit=7.
4. Press and release A, D, *, # in turn, each with a full release debounce -> OP (op_code=00), OP (op_code=11), C, EQ; one pulse each; digit unchanged.
5. Press '0' and '#' together (row3, col1 and col2) -> single num pulse, digit=0; no EQ pulse until release and a fresh '#' press.
6. Assert reset for 1 cycle mid-DEBOUNCE of key '9' -> next cycle row_n=1110 and no num pulse; scanning restarts at row 0.
